// File: rtl/shift_sub_divider_if.sv
// Operand/result bundle for shift_sub_divider.
// The slave side is the divider and the master side is the requester.
interface shift_sub_divider_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/shift_sub_divider.sv
// Sequential restoring unsigned divider that produces one quotient bit per clock.
// The result appears N+1 edges after start is accepted, or 1 edge after start when dividing by zero.
module shift_sub_divider #(
  parameter int unsigned N = 8
) (
  input logic                 clk,
  input logic                 rst,
  shift_sub_divider_if.slave  bus
);
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t         state_q;
  logic [N-1:0]   q_q;
  logic [N-1:0]   m_q;
  logic [N-1:0]   r_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   quot_q;
  logic [N-1:0]   rem_q;
  logic           busy_q;
  logic           done_q;
  logic           dz_q;

  logic [N:0]     trial_d;
  logic [N:0]     diff_d;

  // R < M always holds, so R fits in N bits. Only the trial value needs the extra bit.
  always_comb begin
    trial_d = {r_q, q_q[N-1]};
    diff_d  = trial_d - {1'b0, m_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            q_q     <= bus.dividend;
            m_q     <= bus.divisor;
            r_q     <= '0;
            cnt_q   <= CW'(N);
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            state_q <= (bus.divisor == '0) ? FINISH : CALC;
          end
        end
        CALC: begin
          if (!diff_d[N]) begin
            r_q <= diff_d[N-1:0];
            q_q <= {q_q[N-2:0], 1'b1};
          end else begin
            r_q <= trial_d[N-1:0];
            q_q <= {q_q[N-2:0], 1'b0};
          end
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FINISH;
        end
        FINISH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
          // On the zero-divisor path CALC is skipped, so Q still holds the dividend.
          if (m_q == '0) begin
            quot_q <= '1;
            rem_q  <= q_q;
            dz_q   <= 1'b1;
          end else begin
            quot_q <= q_q;
            rem_q  <= r_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
endmodule
